// File: rtl/seg_value_formatter_pkg.sv
// -----------------------------------------------------------------------------
// seg_fmt_pkg
// Shared constants for the 7-segment value formatter:
//   - SEG_TABLE : 16 glyphs (0..F), active-high {dp,g,f,e,d,c,b,a}
//   - SEG_DASH / SEG_BLANK glyphs
//   - MODE_HEX / MODE_DEC encodings of the MODE input
//   - state_t   : formatter FSM states
//   - BCD_W / NUM_ITER : double-dabble sizing
//   - bcd_adjust() : add-3 correction applied before every shift
// -----------------------------------------------------------------------------
package seg_fmt_pkg;

    // Entry i lives in bits [i*8 +: 8]; listed from F down to 0.
    localparam logic [127:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ENC  = 2'd2
    } state_t;

    localparam int BCD_W    = 20;
    localparam int NUM_ITER = 16;

    // Every BCD digit that is 5 or more gets +3 so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_value_formatter_if.sv
// -----------------------------------------------------------------------------
// seg_value_formatter_if
// Request/result bundle between a caller (master) and the formatter (slave).
//   LOAD, VALUE, MODE, BLANK_LZ, DP_IN : request, driven by master
//   BUSY, DONE, OVF, SEG_A_0..SEG_D_0  : status and held patterns, driven by slave
//   DBG_STATE                           : formatter FSM state, for observation
//
// Handshake: LOAD is a single-cycle request with no ready/ack. It is accepted
// only on a clock edge where BUSY is 0 (the DONE cycle counts as idle);
// a LOAD while BUSY is 1 is dropped, so the master must wait for BUSY=0.
// DONE pulses for exactly one cycle when the new patterns and OVF appear.
// -----------------------------------------------------------------------------
interface seg_value_formatter_if;
    import seg_fmt_pkg::*;

    logic        LOAD;
    logic [15:0] VALUE;
    logic        MODE;
    logic        BLANK_LZ;
    logic [3:0]  DP_IN;

    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic [7:0]  SEG_A_0;
    logic [7:0]  SEG_B_0;
    logic [7:0]  SEG_C_0;
    logic [7:0]  SEG_D_0;
    state_t      DBG_STATE;

    modport master (
        output LOAD, VALUE, MODE, BLANK_LZ, DP_IN,
        input  BUSY, DONE, OVF, SEG_A_0, SEG_B_0, SEG_C_0, SEG_D_0, DBG_STATE
    );

    modport slave (
        input  LOAD, VALUE, MODE, BLANK_LZ, DP_IN,
        output BUSY, DONE, OVF, SEG_A_0, SEG_B_0, SEG_C_0, SEG_D_0, DBG_STATE
    );

endinterface

// File: rtl/seg_value_formatter_digit_encoder.sv
// -----------------------------------------------------------------------------
// seg_digit_encoder
// Combinational glyph mapping for one digit, active-high.
//   digit : 4-bit value to show (0..F)
//   blank : show nothing (segments off)
//   dash  : show a dash; wins over blank
//   dp    : decimal point, ORed into bit 7 regardless of blank/dash
//   seg   : {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg_digit_encoder
    import seg_fmt_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_TABLE[{digit, 3'b000} +: 8];
        if (dash) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end
        seg[7] = seg[7] | dp;
    end

endmodule

// File: rtl/seg_value_formatter.sv
// -----------------------------------------------------------------------------
// seg_value_formatter
// Captures a 16-bit value on LOAD and produces four held 7-segment patterns
// for a dynamic scanner. Hex mode decodes nibbles directly; decimal mode runs
// a 16-step double-dabble (one shift per clock) into five BCD digits.
//   CLK, RSTN : clock, asynchronous active-low reset
//   bus       : seg_value_formatter_if.slave (request, status, patterns)
//   SEG_ACTIVE_LOW : 1 inverts every output segment bit (blank = 8'hFF)
// Latency: outputs/DONE update one edge after LOAD (hex) or 17 edges after
// LOAD (decimal).
// -----------------------------------------------------------------------------
module seg_value_formatter
    import seg_fmt_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
)(
    input  logic                  CLK,
    input  logic                  RSTN,
    seg_value_formatter_if.slave  bus
);

    localparam logic [7:0] INV_MASK = {8{SEG_ACTIVE_LOW}};

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [4:0]        cnt_q;
    logic [15:0]       shift_q;
    logic [BCD_W-1:0]  bcd_q;
    logic              blank_lz_q;
    logic [3:0]        dp_q;
    logic [7:0]        seg_a_q, seg_b_q, seg_c_q, seg_d_q;

    // Double-dabble step: correct, then shift {BCD, shift} left by one.
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+15:0]      dd_next;

    always_comb begin
        bcd_adj = bcd_adjust(bcd_q);
        dd_next = {bcd_adj, shift_q} << 1;
    end

    // Hex mode loads its nibbles into bcd_q[15:0] with bcd_q[19:16] = 0, so the
    // same encode path serves both modes and hex can never flag overflow.
    logic       ovf_now;
    logic       blank_d3, blank_d2, blank_d1;
    logic [7:0] enc_a, enc_b, enc_c, enc_d;

    always_comb begin
        ovf_now  = (bcd_q[19:16] != 4'd0);
        blank_d3 = blank_lz_q & (bcd_q[15:12] == 4'd0);
        blank_d2 = blank_d3   & (bcd_q[11:8]  == 4'd0);
        blank_d1 = blank_d2   & (bcd_q[7:4]   == 4'd0);
    end

    seg_digit_encoder u_enc_a (
        .digit (bcd_q[3:0]),
        .blank (1'b0),
        .dash  (ovf_now),
        .dp    (dp_q[0]),
        .seg   (enc_a)
    );

    seg_digit_encoder u_enc_b (
        .digit (bcd_q[7:4]),
        .blank (blank_d1),
        .dash  (ovf_now),
        .dp    (dp_q[1]),
        .seg   (enc_b)
    );

    seg_digit_encoder u_enc_c (
        .digit (bcd_q[11:8]),
        .blank (blank_d2),
        .dash  (ovf_now),
        .dp    (dp_q[2]),
        .seg   (enc_c)
    );

    seg_digit_encoder u_enc_d (
        .digit (bcd_q[15:12]),
        .blank (blank_d3),
        .dash  (ovf_now),
        .dp    (dp_q[3]),
        .seg   (enc_d)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= 5'd0;
            shift_q    <= 16'd0;
            bcd_q      <= '0;
            blank_lz_q <= 1'b0;
            dp_q       <= 4'd0;
            seg_a_q    <= SEG_BLANK ^ INV_MASK;
            seg_b_q    <= SEG_BLANK ^ INV_MASK;
            seg_c_q    <= SEG_BLANK ^ INV_MASK;
            seg_d_q    <= SEG_BLANK ^ INV_MASK;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.LOAD) begin
                        blank_lz_q <= bus.BLANK_LZ;
                        dp_q       <= bus.DP_IN;
                        cnt_q      <= 5'd0;
                        busy_q     <= 1'b1;
                        if (bus.MODE == MODE_HEX) begin
                            bcd_q   <= {4'h0, bus.VALUE};
                            shift_q <= 16'd0;
                            state_q <= ENC;
                        end else begin
                            bcd_q   <= '0;
                            shift_q <= bus.VALUE;
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    {bcd_q, shift_q} <= dd_next;
                    cnt_q            <= cnt_q + 5'd1;
                    if (cnt_q == 5'(NUM_ITER - 1)) begin
                        state_q <= ENC;
                    end
                end
                ENC: begin
                    // LOAD is not looked at here; it is only sampled in IDLE.
                    seg_a_q <= enc_a ^ INV_MASK;
                    seg_b_q <= enc_b ^ INV_MASK;
                    seg_c_q <= enc_c ^ INV_MASK;
                    seg_d_q <= enc_d ^ INV_MASK;
                    ovf_q   <= ovf_now;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.OVF       = ovf_q;
    assign bus.SEG_A_0   = seg_a_q;
    assign bus.SEG_B_0   = seg_b_q;
    assign bus.SEG_C_0   = seg_c_q;
    assign bus.SEG_D_0   = seg_d_q;
    assign bus.DBG_STATE = state_q;

endmodule

// File: tb/tb_seg_value_formatter.sv
// -----------------------------------------------------------------------------
// tb_seg_value_formatter
// Directed bench for seg_value_formatter. Two instances share all inputs:
// dut0 with active-high segments, dut1 with SEG_ACTIVE_LOW=1. Expected result
// words {SEG_D,SEG_C,SEG_B,SEG_A,OVF} for dut0 are queued when a LOAD is
// issued and compared by a monitor on every DONE pulse.
// -----------------------------------------------------------------------------
module tb_seg_value_formatter;
    import seg_fmt_pkg::*;

    localparam int W = 33;

    logic clk;
    logic rstn;

    seg_value_formatter_if vif0 ();
    seg_value_formatter_if vif1 ();

    assign vif1.LOAD     = vif0.LOAD;
    assign vif1.VALUE    = vif0.VALUE;
    assign vif1.MODE     = vif0.MODE;
    assign vif1.BLANK_LZ = vif0.BLANK_LZ;
    assign vif1.DP_IN    = vif0.DP_IN;

    seg_value_formatter #(.SEG_ACTIVE_LOW(1'b0)) dut0 (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (vif0)
    );

    seg_value_formatter #(.SEG_ACTIVE_LOW(1'b1)) dut1 (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (vif1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && vif0.DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 40'd1, 40'd0);
            end else begin
                check("result_word",
                      40'({vif0.SEG_D_0, vif0.SEG_C_0, vif0.SEG_B_0, vif0.SEG_A_0, vif0.OVF}),
                      40'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [15:0] value, input logic mode,
                           input logic blz, input logic [3:0] dp);
        @(negedge clk);
        vif0.LOAD     = 1'b1;
        vif0.VALUE    = value;
        vif0.MODE     = mode;
        vif0.BLANK_LZ = blz;
        vif0.DP_IN    = dp;
        @(negedge clk);
        vif0.LOAD     = 1'b0;
        vif0.VALUE    = 16'hDEAD;
    endtask

    // Counts negedges until DONE is seen (bounded), and BUSY samples before it.
    task automatic wait_done(input int max_cyc, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (vif0.DONE !== 1'b1 && lat < max_cyc) begin
            if (vif0.BUSY === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_case(input string tag, input logic [15:0] value, input logic mode,
                            input logic blz, input logic [3:0] dp,
                            input int exp_lat, input logic [W-1:0] exp_word);
        int lat;
        int busy_cnt;
        exp_q.push_back(exp_word);
        do_load(value, mode, blz, dp);
        wait_done(40, lat, busy_cnt);
        check({tag, "_latency"}, 40'(lat), 40'(exp_lat));
        check({tag, "_busy_cycles"}, 40'(busy_cnt), 40'(exp_lat));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 40'(vif0.DONE), 40'd0);
    endtask

    task automatic check_low(input string tag, input logic [31:0] exp_segs, input logic exp_ovf);
        check(tag, 40'({vif1.SEG_D_0, vif1.SEG_C_0, vif1.SEG_B_0, vif1.SEG_A_0}), 40'(exp_segs));
        check({tag, "_ovf"}, 40'(vif1.OVF), 40'(exp_ovf));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int busy_cnt;

        vif0.LOAD     = 1'b0;
        vif0.VALUE    = 16'h0000;
        vif0.MODE     = 1'b0;
        vif0.BLANK_LZ = 1'b0;
        vif0.DP_IN    = 4'h0;
        rstn          = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_segs", 40'({vif0.SEG_D_0, vif0.SEG_C_0, vif0.SEG_B_0, vif0.SEG_A_0}), 40'h0);
        check("rst_status", 40'({vif0.BUSY, vif0.DONE, vif0.OVF}), 40'h0);
        check("rst_state", 40'(vif0.DBG_STATE), 40'(IDLE));
        check_low("rst_low_segs", 32'hFFFF_FFFF, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // Hex: BEEF
        run_case("hex_beef", 16'hBEEF, MODE_HEX, 1'b0, 4'b0000, 1, {32'h7C79_7971, 1'b0});
        check_low("hex_beef_low", 32'h8386_868E, 1'b0);

        // Decimal: 1234, with a mid-conversion state check
        exp_q.push_back({32'h065B_4F66, 1'b0});
        do_load(16'd1234, MODE_DEC, 1'b0, 4'b0000);
        check("dec_state_conv", 40'(vif0.DBG_STATE), 40'(CONV));
        wait_done(40, lat, busy_cnt);
        check("dec_1234_latency", 40'(lat), 40'd17);
        check("dec_1234_busy_cycles", 40'(busy_cnt), 40'd17);

        // Leading-zero blanking with a DP on a blanked digit
        run_case("dec_7_blank", 16'd7, MODE_DEC, 1'b1, 4'b0010, 17, {32'h0000_8007, 1'b0});
        run_case("dec_0_blank", 16'd0, MODE_DEC, 1'b1, 4'b0000, 17, {32'h0000_003F, 1'b0});

        // Largest non-overflowing decimal value
        run_case("dec_9999", 16'd9999, MODE_DEC, 1'b0, 4'b0000, 17, {32'h6F6F_6F6F, 1'b0});

        // Overflow on both polarities
        run_case("dec_12345", 16'd12345, MODE_DEC, 1'b0, 4'b0000, 17, {32'h4040_4040, 1'b1});
        check_low("dec_12345_low", 32'hBFBF_BFBF, 1'b1);

        // Hex result clears OVF
        run_case("hex_00a5", 16'h00A5, MODE_HEX, 1'b0, 4'b0000, 1, {32'h3F3F_776D, 1'b0});

        // Smallest overflow; blanking ignored, DP bits kept
        run_case("dec_10000", 16'd10000, MODE_DEC, 1'b1, 4'b0101, 17, {32'h40C0_40C0, 1'b1});

        // LOAD while busy is dropped
        exp_q.push_back({32'h065B_4F66, 1'b0});
        do_load(16'd1234, MODE_DEC, 1'b0, 4'b0000);
        repeat (4) @(negedge clk);
        vif0.LOAD  = 1'b1;
        vif0.VALUE = 16'h0001;
        vif0.MODE  = MODE_HEX;
        @(negedge clk);
        vif0.LOAD  = 1'b0;
        wait_done(40, lat, busy_cnt);
        check("ignore_load_latency", 40'(lat), 40'd12);
        @(negedge clk);

        // Set OVF again so the reset below has something to clear
        run_case("dec_12345_again", 16'd12345, MODE_DEC, 1'b0, 4'b0000, 17, {32'h4040_4040, 1'b1});

        // Reset in the middle of a decimal conversion
        do_load(16'd1234, MODE_DEC, 1'b0, 4'b0000);
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_status", 40'({vif0.BUSY, vif0.DONE, vif0.OVF}), 40'h0);
        check("midrst_segs", 40'({vif0.SEG_D_0, vif0.SEG_C_0, vif0.SEG_B_0, vif0.SEG_A_0}), 40'h0);
        check("midrst_state", 40'(vif0.DBG_STATE), 40'(IDLE));
        check_low("midrst_low_segs", 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_stays_idle", 40'({vif0.BUSY, vif0.DONE}), 40'h0);

        // New LOAD after reset: hex with blanking and a DP on a blanked digit
        run_case("hex_0c0d_blank", 16'h0C0D, MODE_HEX, 1'b1, 4'b1000, 1, {32'h8039_3F5E, 1'b0});

        repeat (3) @(negedge clk);
        check("queue_drained", 40'(exp_q.size()), 40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global safety bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
